lcd_bus_writer: RTL and testbench

//  Responder side of the LCD controller handshake. Accepts one write request (Ejecutar) with an
//  RS flag and data byte. Drives the HD44780-style parallel bus (RS, RW, E, DB[7:0]) with

---
 rtl/lcd_bus_writer_pkg.sv | 29 ++
 rtl/lcd_timer.sv | 29 ++
 rtl/lcd_bus_writer.sv | 124 ++++++++++++
 tb/tb_lcd_bus_writer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_bus_writer_pkg.sv
// Shared types, timing defaults and command constants for the LCD bus writer.
// Imported by the top-level writer and its timer sub-module.
package lcd_bus_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_EXEC  = 3'd4,
    ST_ACK   = 3'd5
  } state_t;

  localparam int DEF_T_SETUP      = 4;
  localparam int DEF_T_PULSE      = 13;
  localparam int DEF_T_HOLD       = 2;
  localparam int DEF_T_EXEC_SHORT = 2000;
  localparam int DEF_T_EXEC_LONG  = 82000;
  localparam int DEF_CW           = 17;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Clear (0x01), home (0x02/0x03) and 0x00 all need the long execution wait.
  function automatic logic needs_long_exec(input logic rs, input logic [7:0] data);
    return !rs && ((data & ~(CMD_CLEAR | CMD_HOME)) == 8'h00);
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Down-counter for the bus phase durations: loads a value, counts to zero and holds.
// The zero flag tells the FSM that the current phase has run its course.
module lcd_timer
  import lcd_bus_writer_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          load,
  input  logic [CW-1:0] value,
  output logic          zero
);

  logic [CW-1:0] count_reg;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/lcd_bus_writer.sv
// Drives one HD44780-style write (setup / E pulse / hold / execution wait) per request
// and answers the controller with a four-phase Escrito acknowledge.
module lcd_bus_writer
  import lcd_bus_writer_pkg::*;
#(
  parameter int T_SETUP      = DEF_T_SETUP,
  parameter int T_PULSE      = DEF_T_PULSE,
  parameter int T_HOLD       = DEF_T_HOLD,
  parameter int T_EXEC_SHORT = DEF_T_EXEC_SHORT,
  parameter int T_EXEC_LONG  = DEF_T_EXEC_LONG,
  parameter int CW           = DEF_CW
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Ejecutar,
  input  logic       RS_in,
  input  logic [7:0] Data,
  output logic       Busy,
  output logic       Escrito,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic [7:0] LCD_DB
);

  state_t        state_reg, state_next;
  logic          rs_reg;
  logic [7:0]    data_reg;
  logic          latch_req;
  logic          timer_load;
  logic [CW-1:0] timer_value;
  logic          timer_zero;
  logic          bus_valid;

  lcd_timer #(.CW(CW)) u_timer (
    .Clk   (Clk),
    .Reset (Reset),
    .load  (timer_load),
    .value (timer_value),
    .zero  (timer_zero)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Request is captured once at acceptance; later input changes never reach the bus.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      rs_reg   <= 1'b0;
      data_reg <= 8'h00;
    end else if (latch_req) begin
      rs_reg   <= RS_in;
      data_reg <= Data;
    end
  end

  always_comb begin
    state_next  = state_reg;
    latch_req   = 1'b0;
    timer_load  = 1'b0;
    timer_value = '0;
    case (state_reg)
      ST_IDLE: begin
        if (Ejecutar) begin
          latch_req   = 1'b1;
          timer_load  = 1'b1;
          timer_value = CW'(T_SETUP - 1);
          state_next  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (timer_zero) begin
          timer_load  = 1'b1;
          timer_value = CW'(T_PULSE - 1);
          state_next  = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (timer_zero) begin
          timer_load  = 1'b1;
          timer_value = CW'(T_HOLD - 1);
          state_next  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (timer_zero) begin
          timer_load  = 1'b1;
          timer_value = needs_long_exec(rs_reg, data_reg) ? CW'(T_EXEC_LONG - 1)
                                                          : CW'(T_EXEC_SHORT - 1);
          state_next  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (timer_zero) begin
          state_next = ST_ACK;
        end
      end
      ST_ACK: begin
        // Waiting for the request to drop keeps a held Ejecutar from starting a second write.
        if (!Ejecutar) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus_valid = (state_reg == ST_SETUP) || (state_reg == ST_PULSE) || (state_reg == ST_HOLD);

  assign Busy    = (state_reg != ST_IDLE);
  assign Escrito = (state_reg == ST_ACK);
  assign LCD_E   = (state_reg == ST_PULSE);
  assign LCD_RW  = 1'b0;
  assign LCD_RS  = bus_valid ? rs_reg : 1'b0;
  assign LCD_DB  = bus_valid ? data_reg : 8'h00;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Directed bench for lcd_bus_writer: a cycle-index model of each transfer is compared
// against every output on every cycle, plus literal checks on pulse/ack/busy counts.
module tb_lcd_bus_writer;

  localparam int TS = 2;
  localparam int TP = 3;
  localparam int TH = 1;
  localparam int ES = 5;
  localparam int EL = 20;

  logic       clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Ejecutar = 1'b0;
  logic       RS_in = 1'b0;
  logic [7:0] Data = 8'h00;
  logic       Busy, Escrito, LCD_RS, LCD_RW, LCD_E;
  logic [7:0] LCD_DB;

  always #5 clk = ~clk;

  lcd_bus_writer #(
    .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH),
    .T_EXEC_SHORT(ES), .T_EXEC_LONG(EL), .CW(17)
  ) dut (
    .Clk(clk), .Reset(Reset), .Ejecutar(Ejecutar), .RS_in(RS_in), .Data(Data),
    .Busy(Busy), .Escrito(Escrito), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .LCD_E(LCD_E), .LCD_DB(LCD_DB)
  );

  // Model: a transfer is an index t = 1..L of busy cycles, then ack until the request drops.
  logic       m_active = 1'b0;
  int         m_t = 0;
  logic       m_rs = 1'b0;
  logic [7:0] m_data = 8'h00;

  function automatic int busy_len(input logic rs, input logic [7:0] d);
    return TS + TP + TH + ((!rs && d < 8'h04) ? EL : ES);
  endfunction

  always @(posedge clk) begin
    if (!Reset) begin
      m_active <= 1'b0;
      m_t      <= 0;
      m_rs     <= 1'b0;
      m_data   <= 8'h00;
    end else if (!m_active) begin
      if (Ejecutar) begin
        m_active <= 1'b1;
        m_t      <= 1;
        m_rs     <= RS_in;
        m_data   <= Data;
      end
    end else if (m_t <= busy_len(m_rs, m_data)) begin
      m_t <= m_t + 1;
    end else if (!Ejecutar) begin
      m_active <= 1'b0;
      m_t      <= 0;
    end
  end

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   n_e = 0, n_rs = 0, n_work = 0, n_esc = 0, n_erise = 0;
  int   erise_cyc = 0, busy_rise_cyc = 0, db_efall = 0;
  logic prev_e = 1'b0, prev_busy = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // One clock: sample outputs 1 time unit after the edge and compare with the model.
  task automatic tick();
    int   len;
    logic exp_ack, exp_e, exp_bus;
    @(posedge clk);
    #1;
    cyc++;
    len     = busy_len(m_rs, m_data);
    exp_ack = m_active && (m_t > len);
    exp_e   = m_active && (m_t > TS) && (m_t <= TS + TP);
    exp_bus = m_active && (m_t <= TS + TP + TH);
    chk("busy",    int'(Busy),    int'(m_active));
    chk("escrito", int'(Escrito), int'(exp_ack));
    chk("lcd_e",   int'(LCD_E),   int'(exp_e));
    chk("lcd_rw",  int'(LCD_RW),  0);
    chk("lcd_rs",  int'(LCD_RS),  int'(exp_bus && m_rs));
    chk("lcd_db",  int'(LCD_DB),  exp_bus ? int'(m_data) : 0);
    if (LCD_E) n_e++;
    if (LCD_E && !prev_e) begin
      n_erise++;
      erise_cyc = cyc;
    end
    if (!LCD_E && prev_e) db_efall = int'(LCD_DB);
    if (Busy && !prev_busy) busy_rise_cyc = cyc;
    if (Busy && !Escrito) n_work++;
    if (Escrito) n_esc++;
    if (LCD_RS) n_rs++;
    prev_e    = LCD_E;
    prev_busy = Busy;
  endtask

  task automatic wait_esc(input string name);
    int k = 0;
    while (!Escrito && k < 200) begin
      tick();
      k++;
    end
    chk(name, int'(Escrito), 1);
  endtask

  task automatic wait_e(input string name);
    int k = 0;
    while (!LCD_E && k < 50) begin
      tick();
      k++;
    end
    chk(name, int'(LCD_E), 1);
  endtask

  // Pulsed request, run to completion and back to idle; returns busy cycles before ack.
  task automatic xfer(input logic rs, input logic [7:0] d, output int work);
    int s_work;
    s_work   = n_work;
    RS_in    = rs;
    Data     = d;
    Ejecutar = 1'b1;
    tick();
    Ejecutar = 1'b0;
    wait_esc("xfer_ack_timeout");
    tick();
    work = n_work - s_work;
    $display("xfer rs=%0d data=%02h busy_cycles=%0d", rs, d, work);
  endtask

  initial begin
    int s_e, s_rs, s_work, s_esc, s_erise, w;

    // Reset state
    repeat (3) tick();
    chk("rst_busy", int'(Busy), 0);
    chk("rst_escrito", int'(Escrito), 0);
    chk("rst_e", int'(LCD_E), 0);
    chk("rst_db", int'(LCD_DB), 0);
    Reset = 1'b1;
    tick();

    // 1: data write 0x41
    s_e = n_e; s_rs = n_rs; s_work = n_work; s_esc = n_esc;
    RS_in = 1'b1; Data = 8'h41; Ejecutar = 1'b1;
    tick();
    Ejecutar = 1'b0;
    wait_esc("t1_ack_timeout");
    tick();
    chk("t1_e_cycles", n_e - s_e, 3);
    chk("t1_rs_cycles", n_rs - s_rs, 6);
    chk("t1_busy_before_ack", n_work - s_work, 11);
    chk("t1_e_offset", erise_cyc - busy_rise_cyc, 2);
    chk("t1_ack_cycles", n_esc - s_esc, 1);
    chk("t1_idle", int'(Busy), 0);
    $display("t1 data write 41 done");

    // 2: execution length selection
    xfer(1'b0, 8'h01, w); chk("t2_clear", w, 26);
    xfer(1'b0, 8'h38, w); chk("t2_func_set", w, 11);
    xfer(1'b0, 8'h02, w); chk("t2_home", w, 26);
    xfer(1'b0, 8'h03, w); chk("t2_home3", w, 26);
    xfer(1'b0, 8'h04, w); chk("t2_entry_mode", w, 11);
    xfer(1'b1, 8'h01, w); chk("t2_data_01", w, 11);

    // 3: held request gives exactly one transfer
    s_erise = n_erise;
    RS_in = 1'b1; Data = 8'h41; Ejecutar = 1'b1;
    repeat (40) tick();
    chk("t3_single_pulse", n_erise - s_erise, 1);
    chk("t3_ack_held", int'(Escrito), 1);
    Ejecutar = 1'b0;
    tick();
    chk("t3_ack_release", int'(Escrito), 0);
    chk("t3_idle", int'(Busy), 0);
    $display("t3 held request done");

    // 4: input changes after acceptance do not reach the bus
    RS_in = 1'b1; Data = 8'h41; Ejecutar = 1'b1;
    tick();
    Ejecutar = 1'b0;
    wait_e("t4_e_timeout");
    Data = 8'hFF; RS_in = 1'b0;
    wait_esc("t4_ack_timeout");
    tick();
    chk("t4_db_in_hold", db_efall, 8'h41);
    $display("t4 late data change done");

    // 5: reset during the E pulse aborts the transfer
    RS_in = 1'b1; Data = 8'h41; Ejecutar = 1'b1;
    tick();
    Ejecutar = 1'b0;
    wait_e("t5_e_timeout");
    Reset = 1'b0;
    tick();
    chk("t5_e", int'(LCD_E), 0);
    chk("t5_busy", int'(Busy), 0);
    chk("t5_db", int'(LCD_DB), 0);
    chk("t5_rs", int'(LCD_RS), 0);
    chk("t5_escrito", int'(Escrito), 0);
    Reset = 1'b1;
    s_esc = n_esc;
    repeat (30) tick();
    chk("t5_no_ack", n_esc - s_esc, 0);
    xfer(1'b1, 8'h41, w); chk("t5_after_reset", w, 11);

    // 6: request dropped during EXEC, then immediate re-request
    s_esc = n_esc;
    RS_in = 1'b0; Data = 8'h38; Ejecutar = 1'b1;
    tick();
    repeat (7) tick();
    chk("t6_in_exec", int'(Busy), 1);
    Ejecutar = 1'b0;
    wait_esc("t6_ack_timeout");
    tick();
    chk("t6_ack_once", n_esc - s_esc, 1);
    Ejecutar = 1'b1; Data = 8'h41; RS_in = 1'b1;
    tick();
    chk("t6_restart_busy", int'(Busy), 1);
    chk("t6_restart_setup_e", int'(LCD_E), 0);
    Ejecutar = 1'b0;
    wait_esc("t6_ack2_timeout");
    tick();
    $display("t6 drop in exec and restart done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
